// File: rtl/button_conditioner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner_pkg
//  Description : Shared definitions for the pushbutton / setup-switch front
//                end: clock mode encodings, board-build timing defaults and
//                the lowest-index priority helper used by the output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package button_conditioner_pkg;

    // Mode encodings consumed by the mode-select logic downstream.
    typedef enum logic [1:0] {
        MODE_SETUP   = 2'b00,
        MODE_TIME24  = 2'b01,
        MODE_SECONDS = 2'b10,
        MODE_TIME12  = 2'b11
    } mode_e;

    // Board-build timing values (slow system clock, ~10 ms debounce).
    localparam int BOARD_DEBOUNCE_CYCLES = 500000;
    localparam int BOARD_REPEAT_DELAY    = 800000;
    localparam int BOARD_REPEAT_CYCLES   = 250000;

    localparam int NUM_BUTTONS = 4;

    // One-hot mask of the lowest set bit (all zeros when nothing is set).
    function automatic logic [NUM_BUTTONS-1:0] lowest_set(input logic [NUM_BUTTONS-1:0] v);
        return v & (~v + NUM_BUTTONS'(1));
    endfunction

endpackage : button_conditioner_pkg
`default_nettype wire

// File: rtl/button_conditioner_debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_channel
//  Description : One input channel: 2-flop synchronizer, debounce counter,
//                accepted level ('stable') and a one-cycle 'press' pulse that
//                fires when the accepted level moves from idle to active.
//  Ports       : clk, reset (sync, active-high), raw (async pad input),
//                stable (debounced level), press (1-cycle pulse on activation)
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel #(
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter int   CNT_W           = 20,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic press
);

    localparam logic [CNT_W-1:0] c_DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;
    logic             r_press;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= IDLE_LEVEL;
            r_sync2  <= IDLE_LEVEL;
            r_cnt    <= '0;
            r_stable <= IDLE_LEVEL;
            r_press  <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_stable) begin
                // Any sample agreeing with the accepted level restarts the count.
                r_cnt <= '0;
            end else if (r_cnt == c_DEB_LAST) begin
                // This is the DEBOUNCE_CYCLES-th consecutive differing sample.
                r_stable <= r_sync2;
                r_cnt    <= '0;
                r_press  <= (r_sync2 != IDLE_LEVEL);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign stable = r_stable;
    assign press  = r_press;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner
//  Description : Conditions four active-low pushbuttons and the active-high
//                setup switch. Debounced presses (and optional auto-repeat
//                while held) become single-cycle active-low strobes on
//                'buttons', at most one low bit per cycle, lowest index first.
//  Ports       : clk         - system clock
//                reset       - synchronous, active-high reset
//                raw_buttons - async pad inputs, active-low
//                raw_setup   - async setup switch, active-high
//                buttons     - active-low press strobes (one-cold or all 1s)
//                setUp       - debounced setup level, active-high
//  Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_CYCLES   = 32,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] raw_buttons,
    input  logic       raw_setup,
    output logic [3:0] buttons,
    output logic       setUp
);

    localparam logic [CNT_W-1:0] c_REP_DELAY  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] c_REP_CYCLES = CNT_W'(REPEAT_CYCLES);

    logic [NUM_BUTTONS-1:0] w_stable;   // 0 = stably pressed
    logic [NUM_BUTTONS-1:0] w_press;
    logic [NUM_BUTTONS-1:0] w_rep;
    logic [NUM_BUTTONS-1:0] w_event;
    logic [NUM_BUTTONS-1:0] w_req;
    logic [NUM_BUTTONS-1:0] w_grant;
    logic [NUM_BUTTONS-1:0] r_pending;
    logic [NUM_BUTTONS-1:0] r_buttons;
    logic                   w_setup_stable;
    logic                   w_setup_unused_press;

    // ------------------------------------------------------------------
    // Per-button debounce and auto-repeat
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .IDLE_LEVEL      (1'b1)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .raw    (raw_buttons[i]),
            .stable (w_stable[i]),
            .press  (w_press[i])
        );

        if (REPEAT_DELAY > 0) begin : g_rep
            logic [CNT_W-1:0] r_rep_cnt;
            logic             r_rep_first;
            logic             w_held;

            // The counter sits at 0 in the cycle the press is accepted and
            // then counts cycles held, so it equals the limit exactly
            // REPEAT_DELAY (then REPEAT_CYCLES) cycles after the press event.
            assign w_held   = ~w_stable[i];
            assign w_rep[i] = w_held &&
                              (r_rep_cnt == (r_rep_first ? c_REP_DELAY : c_REP_CYCLES));

            always_ff @(posedge clk) begin
                if (reset || !w_held) begin
                    r_rep_cnt   <= '0;
                    r_rep_first <= 1'b1;
                end else if (w_rep[i]) begin
                    r_rep_cnt   <= CNT_W'(1);
                    r_rep_first <= 1'b0;
                end else begin
                    r_rep_cnt   <= r_rep_cnt + CNT_W'(1);
                end
            end
        end else begin : g_norep
            assign w_rep[i] = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Setup switch channel (level only; its press pulse is not needed)
    // ------------------------------------------------------------------
    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .IDLE_LEVEL      (1'b0)
    ) u_setup (
        .clk    (clk),
        .reset  (reset),
        .raw    (raw_setup),
        .stable (w_setup_stable),
        .press  (w_setup_unused_press)
    );

    // ------------------------------------------------------------------
    // Pending / priority output stage
    // ------------------------------------------------------------------
    // Fresh events join the request set in the same cycle so an uncontended
    // press is strobed on the very next edge; an event on an already
    // pending bit simply merges into it.
    always_comb begin
        w_event = w_press | w_rep;
        w_req   = r_pending | w_event;
        w_grant = lowest_set(w_req);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
            r_buttons <= '1;
        end else begin
            r_pending <= w_req & ~w_grant;
            r_buttons <= ~w_grant;
        end
    end

    assign buttons = r_buttons;
    assign setUp   = w_setup_stable;

endmodule : button_conditioner
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_conditioner
//  Description : Directed self-checking bench for button_conditioner with
//                DEBOUNCE_CYCLES=16, REPEAT_DELAY=64, REPEAT_CYCLES=32.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    logic       clk;
    logic       reset;
    logic [3:0] raw_buttons;
    logic       raw_setup;
    logic [3:0] buttons;
    logic       setUp;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES (16),
        .REPEAT_DELAY    (64),
        .REPEAT_CYCLES   (32),
        .CNT_W           (20)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .raw_buttons (raw_buttons),
        .raw_setup   (raw_setup),
        .buttons     (buttons),
        .setUp       (setUp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs changed after this are
    // first sampled by the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    // Tick n times; buttons must equal pat at tick t0 and 4'b1111 otherwise.
    task automatic watch(input string tag, input int n, input int t0, input logic [3:0] pat);
        for (int t = 1; t <= n; t++) begin
            tick();
            check(tag, buttons, (t == t0) ? pat : 4'b1111);
        end
    endtask

    initial begin
        reset       = 1'b1;
        raw_buttons = 4'b1111;
        raw_setup   = 1'b0;

        // ---------------- reset state ----------------
        for (int t = 0; t < 3; t++) begin
            tick();
            check("rst_buttons", buttons, 4'b1111);
            check("rst_setup", {3'b000, setUp}, 4'b0000);
        end
        reset = 1'b0;
        for (int t = 0; t < 8; t++) begin
            tick();
            check("idle_buttons", buttons, 4'b1111);
            check("idle_setup", {3'b000, setUp}, 4'b0000);
        end

        // ---------------- single press, button 0 ----------------
        // Sampled at edge N=+1; strobe registered at N+2+16 = tick 19.
        raw_buttons = 4'b1110;
        watch("press0", 20, 19, 4'b1110);
        raw_buttons = 4'b1111;
        watch("release0", 25, 0, 4'b1111);

        // ---------------- bouncing button 1 ----------------
        for (int r = 0; r < 3; r++) begin
            raw_buttons = 4'b1101;
            watch("bounce_low", 5, 0, 4'b1111);
            raw_buttons = 4'b1111;
            watch("bounce_high", 3, 0, 4'b1111);
        end
        raw_buttons = 4'b1101;
        watch("press1", 20, 19, 4'b1101);
        raw_buttons = 4'b1111;
        watch("release1", 25, 0, 4'b1111);

        // ---------------- all four at once ----------------
        raw_buttons = 4'b0000;
        for (int t = 1; t <= 23; t++) begin
            logic [3:0] e;
            tick();
            case (t)
                19:      e = 4'b1110;
                20:      e = 4'b1101;
                21:      e = 4'b1011;
                22:      e = 4'b0111;
                default: e = 4'b1111;
            endcase
            check("all4", buttons, e);
        end
        raw_buttons = 4'b1111;
        watch("release_all", 25, 0, 4'b1111);

        // ---------------- auto-repeat on button 2 ----------------
        // Initial strobe at tick 19, repeats at 83, 115, 147, 179, 211.
        // Released after tick 200; stable releases at tick 218 so no
        // strobe at 243.
        raw_buttons = 4'b1011;
        for (int t = 1; t <= 260; t++) begin
            logic [3:0] e;
            tick();
            case (t)
                19, 83, 115, 147, 179, 211: e = 4'b1011;
                default:                    e = 4'b1111;
            endcase
            check("repeat2", buttons, e);
            if (t == 200) raw_buttons = 4'b1111;
        end

        // ---------------- setup switch with reset mid-debounce ----------------
        // Rise sampled at tick 1; reset sampled at tick 12 discards progress.
        // Re-sampled at tick 13, so setUp rises at tick 13+17 = 30.
        raw_setup = 1'b1;
        for (int t = 1; t <= 35; t++) begin
            tick();
            check("setup_lvl", {3'b000, setUp}, (t >= 30) ? 4'b0001 : 4'b0000);
            check("setup_btn", buttons, 4'b1111);
            if (t == 11) reset = 1'b1;
            if (t == 12) reset = 1'b0;
        end
        raw_setup = 1'b0;
        for (int t = 1; t <= 19; t++) begin
            tick();
            check("setup_fall", {3'b000, setUp}, (t >= 18) ? 4'b0000 : 4'b0001);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_button_conditioner
`default_nettype wire
